// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshakes and register-file write port bundle
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int NUM_REGS = 32,
  parameter int SEL_W = 5
);
  logic ValidA;
  logic [SEL_W-1:0] RegA;
  logic [DATA_W-1:0] DataA;
  logic ReadyA;
  logic ValidB;
  logic [SEL_W-1:0] RegB;
  logic [DATA_W-1:0] DataB;
  logic ReadyB;
  logic Stall;
  logic [NUM_REGS-1:0] WriteEn;
  logic [DATA_W-1:0] WriteData;
  logic WriteValid;
  logic [SEL_W-1:0] WriteReg;
  modport master (
    output ValidA, RegA, DataA, ValidB, RegB, DataB, Stall,
    input ReadyA, ReadyB, WriteEn, WriteData, WriteValid, WriteReg
  );
  modport slave (
    input ValidA, RegA, DataA, ValidB, RegB, DataB, Stall,
    output ReadyA, ReadyB, WriteEn, WriteData, WriteValid, WriteReg
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the register-file write port (REGFILE_WRITE_ARBITER_FIXED_PRIO_EN selects fixed A-first priority)
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int NUM_REGS = 32,
  parameter int SEL_W = 5
) (
  input logic clk,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);
  logic open, grant_a, grant_b, grant;
  logic [SEL_W-1:0] sel;
  assign open = !reset && !bus.Stall;
`ifdef REGFILE_WRITE_ARBITER_FIXED_PRIO_EN
  assign grant_a = open && bus.ValidA;
  assign grant_b = open && bus.ValidB && !bus.ValidA;
`else
  logic last_b;
  assign grant_a = open && bus.ValidA && (!bus.ValidB || last_b);
  assign grant_b = open && bus.ValidB && (!bus.ValidA || !last_b);
  // Remember who won last so the other side wins the next contention
  always_ff @(posedge clk)
    if (reset) last_b <= 1'b1;
    else if (grant_a || grant_b) last_b <= grant_b;
`endif
  assign grant = grant_a || grant_b;
  assign bus.ReadyA = grant_a;
  assign bus.ReadyB = grant_b;
  assign sel = grant_a ? bus.RegA : bus.RegB;
  // Output stage: one-cycle registered write; zero register gets no enable
  always_ff @(posedge clk)
    if (reset) begin
      bus.WriteValid <= 1'b0;
      bus.WriteReg <= '0;
      bus.WriteData <= '0;
      bus.WriteEn <= '0;
    end else begin
      bus.WriteValid <= grant;
      bus.WriteReg <= grant ? sel : '0;
      bus.WriteData <= grant_a ? bus.DataA : grant_b ? bus.DataB : '0;
      bus.WriteEn <= (grant && sel != SEL_W'(NUM_REGS - 1)) ? NUM_REGS'(1) << sel : '0;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench for the register-file write arbiter
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  regfile_write_arbiter_if #(.DATA_W(64), .NUM_REGS(32), .SEL_W(5)) bus ();
  regfile_write_arbiter #(.DATA_W(64), .NUM_REGS(32), .SEL_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  typedef struct packed {
    logic v;
    logic [4:0] r;
    logic [31:0] en;
    logic [63:0] d;
  } wr_t;
  wr_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic m_last_b = 1'b1;
  logic ga, gb;
  logic [63:0] rf [32];
  always @(posedge clk)
    for (int i = 0; i < 32; i++) if (bus.WriteEn[i]) rf[i] <= bus.WriteData;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic wr_t mk(input logic v, input logic [4:0] r, input logic [63:0] d);
    wr_t w;
    w.v = v;
    w.r = v ? r : 5'd0;
    w.en = (v && r != 5'd31) ? (32'd1 << r) : 32'd0;
    w.d = v ? d : 64'd0;
    return w;
  endfunction
  task automatic cycle();
    wr_t e;
    logic ok;
    @(negedge clk);
    ok = !reset && !bus.Stall;
`ifdef REGFILE_WRITE_ARBITER_FIXED_PRIO_EN
    ga = ok && bus.ValidA;
    gb = ok && bus.ValidB && !bus.ValidA;
`else
    ga = ok && bus.ValidA && (!bus.ValidB || m_last_b);
    gb = ok && bus.ValidB && (!bus.ValidA || !m_last_b);
`endif
    check("ReadyA", 64'(bus.ReadyA), 64'(ga));
    check("ReadyB", 64'(bus.ReadyB), 64'(gb));
    check("WriteEn_onehot0", 64'($onehot0(bus.WriteEn) && (bus.WriteEn == 0 || bus.WriteValid)), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("WriteValid", 64'(bus.WriteValid), 64'(e.v));
      check("WriteReg", 64'(bus.WriteReg), 64'(e.r));
      check("WriteEn", 64'(bus.WriteEn), 64'(e.en));
      check("WriteData", bus.WriteData, e.d);
    end
    exp_q.push_back(ga ? mk(1'b1, bus.RegA, bus.DataA) : gb ? mk(1'b1, bus.RegB, bus.DataB) : mk(1'b0, 5'd0, 64'd0));
    if (reset) m_last_b = 1'b1;
    else if (ga || gb) m_last_b = gb;
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int budget = 8;
    while ((bus.ValidA || bus.ValidB) && budget > 0) begin
      cycle();
      if (ga) bus.ValidA = 1'b0;
      if (gb) bus.ValidB = 1'b0;
      budget--;
    end
    check("drain", 64'({bus.ValidA, bus.ValidB}), 64'd0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask
  initial begin
    bus.ValidA = 1'b0;
    bus.RegA = '0;
    bus.DataA = '0;
    bus.ValidB = 1'b0;
    bus.RegB = '0;
    bus.DataB = '0;
    bus.Stall = 1'b0;
    do_reset();
    bus.ValidA = 1'b1;
    bus.RegA = 5'd3;
    bus.DataA = 64'h00A0000000FFF000;
    drain();
    cycle();
    cycle();
    do_reset();
    bus.ValidA = 1'b1;
    bus.RegA = 5'd1;
    bus.DataA = 64'h1111;
    bus.ValidB = 1'b1;
    bus.RegB = 5'd2;
    bus.DataB = 64'h2222;
    repeat (4) cycle();
    bus.ValidA = 1'b0;
    bus.ValidB = 1'b0;
    cycle();
    bus.ValidB = 1'b1;
    bus.RegB = 5'd31;
    bus.DataB = 64'hFFFFFFFFFFFFFFFF;
    drain();
    cycle();
    bus.ValidA = 1'b1;
    bus.RegA = 5'd10;
    bus.DataA = 64'hAAAA;
    bus.ValidB = 1'b1;
    bus.RegB = 5'd20;
    bus.DataB = 64'hBBBB;
    bus.Stall = 1'b1;
    repeat (3) cycle();
    bus.Stall = 1'b0;
    drain();
    cycle();
    do_reset();
    bus.ValidA = 1'b1;
    bus.RegA = 5'd7;
    bus.DataA = 64'h1;
    bus.ValidB = 1'b1;
    bus.RegB = 5'd7;
    bus.DataB = 64'h2;
    drain();
    cycle();
    cycle();
    check("rf7_final", rf[7], 64'h2);
    bus.ValidA = 1'b1;
    bus.RegA = 5'd5;
    bus.DataA = 64'h5555;
    cycle();
    bus.ValidA = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.ValidA = 1'b1;
    bus.RegA = 5'd4;
    bus.DataA = 64'h4444;
    bus.ValidB = 1'b1;
    bus.RegB = 5'd6;
    bus.DataB = 64'h6666;
    cycle();
    check("post_reset_A_first", 64'(bus.ValidA), 64'd1);
    if (ga) bus.ValidA = 1'b0;
    if (gb) bus.ValidB = 1'b0;
    drain();
    cycle();
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32 x 64-bit register file between two writeback requesters: A (ALU) and B (memory load).
- The register file is built from 64-bit write-enabled registers.
- Arbitrates round-robin with valid/ready handshakes.
- Registers the winning write and drives a one-hot per-register write-enable vector plus the 64-bit write data. Register 31 is the zero register and is never written.

Parameters:
- DATA_W, 64, width of write data.
- NUM_REGS, 32, number of architectural registers; index NUM_REGS-1 is the zero register.
- SEL_W, 5, register index width (log2 NUM_REGS).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ValidA  input  1  requester A has a write pending.
- RegA  input  SEL_W  destination register of A.
- DataA  input  DATA_W  write data of A.
- ReadyA  output  1  A's request accepted this cycle.
- ValidB  input  1  requester B has a write pending.
- RegB  input  SEL_W  destination register of B.
- DataB  input  DATA_W  write data of B.
- ReadyB  output  1  B's request accepted this cycle.
- Stall  input  1  blocks new grants (register file busy).
- WriteEn  output  NUM_REGS  one-hot write enables to the register file.
- WriteData  output  DATA_W  data to all register DataIn inputs.
- WriteValid  output  1  a granted write is in the output stage.
- WriteReg  output  SEL_W  index of the write in the output stage (for hazard/forward logic).

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled only on rising clk.
- Reset values, held in the cycle after reset is sampled high: WriteEn=0, WriteData=0, WriteValid=0, WriteReg=0. LastGrant=B, so A wins the first contention.
- ReadyA/ReadyB are forced 0 in any cycle where reset=1.
- Handshake: a transfer occurs in a cycle where Valid&Ready are both high. Requester holds Valid/Reg/Data stable until Ready. Valid must not depend on Ready.
- Ready is combinational from ValidA, ValidB, Stall, reset and LastGrant. At most one of ReadyA/ReadyB is high per cycle.
- Grant rules:
  - Stall=1: no grant.
  - Only one Valid: that requester is granted.
  - Both Valid: the requester not equal to LastGrant is granted.
  - LastGrant updates on every grant.
- Latency: a grant in cycle n puts the write in the output stage in cycle n+1.
  - WriteValid=1, WriteReg=granted Reg, WriteData=granted Data.
  - WriteEn = one-hot decode of Reg.
  - The register file captures on the rising edge ending cycle n+1.
- Output stage holds a write for exactly one cycle. With no grant in cycle n, WriteValid=0, WriteEn=0 and WriteData=0 in cycle n+1.
- Zero register: a request to Reg=NUM_REGS-1 is handshaken normally. WriteValid=1 and WriteReg=31 in the output stage, but WriteEn is all zeros.
- Stall does not affect the output stage: a write already granted is still issued.
- Same destination from both requesters in one cycle: the writes are serialised. The second-granted write lands one cycle later and its value persists.
- Throughput: one write per cycle. Back-to-back writes from one requester are legal with no bubble.
- Reset mid-operation: the pending output-stage write is discarded (WriteEn=0 next cycle). No grant is issued in the reset cycle.
- Invariants: WriteEn is zero or one-hot, and non-zero only if WriteValid=1.

Optional Feature:
- Macro: REGFILE_WRITE_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority; A always wins when both are valid. LastGrant is not implemented; B is granted only when ValidA=0.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then single write: reset 1 cycle; ValidA=1, RegA=3, DataA=64'h00A0000000FFF000.
  - ReadyA=1 that cycle.
  - Next cycle WriteEn=32'h00000008, WriteData=64'h00A0000000FFF000, WriteValid=1.
  - Following cycle WriteEn=0.
- Contention round-robin: both valid for 4 cycles, RegA=1, RegB=2, after reset.
  - Grants A,B,A,B.
  - WriteEn sequence 2,4,2,4 one cycle delayed.
  - (With the macro defined: A every cycle, WriteEn=2 throughout, ReadyB=0.)
- Zero register: ValidB=1, RegB=31, DataB=64'hFFFFFFFFFFFFFFFF.
  - ReadyB=1.
  - Next cycle WriteValid=1, WriteReg=31, WriteEn=0.
- Stall: both valid, Stall=1 for 3 cycles.
  - ReadyA=ReadyB=0; WriteEn stays 0 once the prior write drains.
  - Stall drops: grant resumes in the same cycle.
- Same-register collision: RegA=RegB=7, DataA=64'h1, DataB=64'h2, both valid one cycle, then each held until accepted.
  - Two consecutive cycles of WriteEn=32'h80: data 1 then 2.
  - Register 7 ends at 64'h2.
- Reset mid-operation: grant A (RegA=5) in cycle n, assert reset in cycle n+1.
  - WriteEn=0 in cycle n+2.
  - Afterwards both valid: A wins first.
